// File: rtl/mem_arb_pkg.sv
// Shared encodings for the system-RAM arbiter: FSM states, owner ids, latency limits.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ACK   = 2'b11
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int MEM_LAT_MAX = 4;
  // Wide enough to hold MEM_LAT_MAX.
  localparam int CNT_W = 3;

  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between CPU and debug requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant_owner
);

  assign grant_valid = cpu_req | dbg_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_owner = OWN_CPU;
    if (cpu_req && dbg_req)
      grant_owner = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
    else if (dbg_req)
      grant_owner = OWN_DBG;
  end
`else
  // Fixed priority has no use for the history input.
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  always_comb begin
    grant_owner = OWN_CPU;
    if (!cpu_req && dbg_req)
      grant_owner = OWN_DBG;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and debug/loader accesses onto the single-port system RAM,
// absorbing MEM_LAT cycles of read latency. MEM_ARB_RR_EN enables round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  if (!lat_ok(MEM_LAT)) begin : g_lat_chk
    $error("mem_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MEM_LAT_MAX);
  end

  typedef struct packed {
    owner_t              own;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  state_t             r_state, w_next;
  req_t               r_req, w_req;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_cpu_rdata, r_dbg_rdata;
  logic               w_grant_valid, w_grant, w_capture;
  owner_t             w_grant_owner, w_last_grant;

  mem_arb_select u_select (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .last_grant  (w_last_grant),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  assign w_grant   = (r_state == IDLE) && w_grant_valid;
  assign w_capture = (r_state == WAIT) && (r_cnt == CNT_W'(1));

`ifdef MEM_ARB_RR_EN
  owner_t r_last_grant;
  always_ff @(posedge clock) begin
    if (clear)        r_last_grant <= OWN_DBG;
    else if (w_grant) r_last_grant <= w_grant_owner;
  end
  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = OWN_DBG;
`endif

  // Request fields frozen at grant; later requester changes are ignored.
  always_comb begin
    w_req.own = w_grant_owner;
    if (w_grant_owner == OWN_CPU) begin
      w_req.we    = cpu_we;
      w_req.addr  = cpu_addr;
      w_req.wdata = cpu_wdata;
    end else begin
      w_req.we    = dbg_we;
      w_req.addr  = dbg_addr;
      w_req.wdata = dbg_wdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next = ISSUE;
      ISSUE:   w_next = r_req.we ? ACK : WAIT;
      WAIT:    if (r_cnt == CNT_W'(1)) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) r_req <= w_req;
      if (r_state == ISSUE && !r_req.we) r_cnt <= CNT_W'(MEM_LAT);
      else if (r_state == WAIT)          r_cnt <= r_cnt - CNT_W'(1);
      // Read data lands only in the owner's register, in the counter==1 cycle.
      if (w_capture) begin
        if (r_req.own == OWN_CPU) r_cpu_rdata <= ram_rdata;
        else                      r_dbg_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en    = (r_state == ISSUE);
  assign ram_we    = ram_en & r_req.we;
  assign ram_addr  = r_req.addr;
  assign ram_wdata = r_req.wdata;
  assign cpu_ack   = (r_state == ACK) && (r_req.own == OWN_CPU);
  assign dbg_ack   = (r_state == ACK) && (r_req.own == OWN_DBG);
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) each with a RAM model,
// directed tables, hand sequences and a randomized scoreboard run.
module tb_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          clear[2], cpu_req[2], cpu_we[2], cpu_ack[2], dbg_req[2], dbg_we[2], dbg_ack[2];
  logic          ram_en[2], ram_we[2], busy[2];
  logic [AW-1:0] cpu_addr[2], dbg_addr[2], ram_addr[2];
  logic [DW-1:0] cpu_wdata[2], cpu_rdata[2], dbg_wdata[2], dbg_rdata[2], ram_wdata[2], ram_rdata[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
      .clock(clock), .clear(clear[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]), .dbg_wdata(dbg_wdata[g]),
      .dbg_ack(dbg_ack[g]), .dbg_rdata(dbg_rdata[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g]), .busy(busy[g]));

    // RAM with L cycles from strobe to data; garbage on the bus when not reading.
    logic [DW-1:0] mem [512];
    logic [DW-1:0] pipe [L];
    always @(posedge clock) begin
      if (ram_en[g]) begin
        if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
        pipe[0] <= mem[ram_addr[g]];
      end else begin
        pipe[0] <= $urandom();
      end
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[g] = pipe[L-1];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm, input int waited);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no completion after %0d cycles, expected completion", nm, waited);
  endtask

  task automatic set_req(input int k, input int p, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      cpu_req[k] = r; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
    end else begin
      dbg_req[k] = r; dbg_we[k] = we; dbg_addr[k] = a; dbg_wdata[k] = d;
    end
  endtask

  function automatic logic get_ack(input int k, input int p);
    return (p == 0) ? cpu_ack[k] : dbg_ack[k];
  endfunction

  function automatic logic [DW-1:0] get_rd(input int k, input int p);
    return (p == 0) ? cpu_rdata[k] : dbg_rdata[k];
  endfunction

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (busy[k]) bound_fail($sformatf("idle_k%0d", k), n);
  endtask

  // Single access; n = cycle of ack counted from the request cycle c0 (0 on timeout).
  task automatic access(input int k, input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int n, output logic [DW-1:0] rd);
    wait_idle(k);
    set_req(k, p, 1'b1, we, a, d);
    n = 0;
    rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (get_ack(k, p)) begin
        n = i;
        rd = get_rd(k, p);
        break;
      end
    end
    set_req(k, p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_clear(input int k);
    set_req(k, 0, 1'b0, 1'b0, '0, '0);
    set_req(k, 1, 1'b0, 1'b0, '0, '0);
    clear[k] = 1'b1;
    @(negedge clock);
    clear[k] = 1'b0;
  endtask

  // Both requesters raise together; keep=1 means each re-requests immediately after its ack.
  task automatic tie_run(input int k, input bit keep, input int nacks);
    int pc, pd, got, lgm, w, ew, last_i;
    pulse_clear(k);
    lgm = 1;
    set_req(k, 0, 1'b1, 1'b1, 9'h030, 32'hC0C0_0001);
    set_req(k, 1, 1'b1, 1'b1, 9'h031, 32'hDB00_0002);
    pc = 1; pd = 1; got = 0; last_i = 0;
    for (int i = 1; i <= 80 && got < nacks; i++) begin
      @(negedge clock);
      last_i = i;
      if (cpu_ack[k] || dbg_ack[k]) begin
        w = cpu_ack[k] ? 0 : 1;
        if (pc != 0 && pd != 0) begin
`ifdef MEM_ARB_RR_EN
          ew = (lgm == 0) ? 1 : 0;
`else
          ew = 0;
`endif
        end else begin
          ew = (pc != 0) ? 0 : 1;
        end
        chk($sformatf("tie_k%0d_keep%0d_ack%0d_owner", k, keep, got), w, ew);
        if (!keep) chk($sformatf("tie_k%0d_ack%0d_cycle", k, got), i, (got == 0) ? 2 : 5);
        lgm = w;
        got++;
        if (!keep) begin
          if (w == 0) begin pc = 0; set_req(k, 0, 1'b0, 1'b0, '0, '0); end
          else        begin pd = 0; set_req(k, 1, 1'b0, 1'b0, '0, '0); end
        end
      end
    end
    if (got < nacks) bound_fail($sformatf("tie_k%0d_keep%0d", k, keep), last_i);
    set_req(k, 0, 1'b0, 1'b0, '0, '0);
    set_req(k, 1, 1'b0, 1'b0, '0, '0);
    wait_idle(k);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    int            lat1;
    int            lat3;
  } vec_t;

  vec_t vt[9];
  int n;
  logic [DW-1:0] rd;
  logic [DW-1:0] sb[8];
  logic [DW-1:0] last_rd[2];
  int pend[2], pw[2], ps[2], age[2];
  logic [DW-1:0] pdat[2];
  int acks_seen;

  function automatic logic [AW-1:0] slot_addr(input int s);
    return AW'(s * 37 + 5);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b1;
      set_req(k, 0, 1'b0, 1'b0, '0, '0);
      set_req(k, 1, 1'b0, 1'b0, '0, '0);
    end
    vt[0] = '{1'b1, 9'h055, 32'hDEADBEEF, 32'h0,        2, 2};
    vt[1] = '{1'b0, 9'h055, 32'h0,        32'hDEADBEEF, 3, 5};
    vt[2] = '{1'b1, 9'h000, 32'h00000001, 32'h0,        2, 2};
    vt[3] = '{1'b1, 9'h1FF, 32'hFFFFFFFF, 32'h0,        2, 2};
    vt[4] = '{1'b0, 9'h000, 32'h0,        32'h00000001, 3, 5};
    vt[5] = '{1'b0, 9'h1FF, 32'h0,        32'hFFFFFFFF, 3, 5};
    vt[6] = '{1'b1, 9'h055, 32'h0BADF00D, 32'h0,        2, 2};
    vt[7] = '{1'b0, 9'h055, 32'h0,        32'h0BADF00D, 3, 5};
    vt[8] = '{1'b0, 9'h1FF, 32'h0,        32'hFFFFFFFF, 3, 5};

    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_k%0d_strobes", k), {ram_en[k], ram_we[k], cpu_ack[k], dbg_ack[k], busy[k]}, 0);
      chk($sformatf("rst_k%0d_ram_addr", k), ram_addr[k], 0);
      chk($sformatf("rst_k%0d_ram_wdata", k), ram_wdata[k], 0);
      chk($sformatf("rst_k%0d_cpu_rdata", k), cpu_rdata[k], 0);
      chk($sformatf("rst_k%0d_dbg_rdata", k), dbg_rdata[k], 0);
      clear[k] = 1'b0;
    end
    @(negedge clock);

    // CPU write strobe timing, MEM_LAT=1
    set_req(0, 0, 1'b1, 1'b1, 9'h055, 32'hDEADBEEF);
    @(negedge clock);
    chk("A_c1_ram_en", ram_en[0], 1);
    chk("A_c1_ram_we", ram_we[0], 1);
    chk("A_c1_ram_addr", ram_addr[0], 32'h055);
    chk("A_c1_ram_wdata", ram_wdata[0], 32'hDEADBEEF);
    chk("A_c1_ack", cpu_ack[0], 0);
    @(negedge clock);
    chk("A_c2_ack", cpu_ack[0], 1);
    chk("A_c2_ram_en", ram_en[0], 0);
    set_req(0, 0, 1'b0, 1'b0, '0, '0);
    access(0, 0, 1'b0, 9'h055, '0, n, rd);
    chk("A_rd_lat", n, 3);
    chk("A_rd_data", rd, 32'hDEADBEEF);
    chk("A_dbg_rdata", dbg_rdata[0], 0);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++) begin
        access(k, 0, vt[i].we, vt[i].addr, vt[i].wdata, n, rd);
        chk($sformatf("vec%0d_k%0d_lat", i, k), n, (k == 0) ? vt[i].lat1 : vt[i].lat3);
        if (!vt[i].we) chk($sformatf("vec%0d_k%0d_rdata", i, k), rd, vt[i].exp_rd);
        chk($sformatf("vec%0d_k%0d_dbg_rdata", i, k), dbg_rdata[k], 0);
      end
    end

    // Debug read, MEM_LAT=3: busy c1..c5, one strobe, ack in c5
    access(1, 1, 1'b1, 9'h1FF, 32'h12345678, n, rd);
    wait_idle(1);
    set_req(1, 1, 1'b1, 1'b0, 9'h1FF, '0);
    chk("B_c0_busy", busy[1], 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      chk($sformatf("B_c%0d_busy", i), busy[1], (i <= 5) ? 1 : 0);
      chk($sformatf("B_c%0d_ram_en", i), ram_en[1], (i == 1) ? 1 : 0);
      chk($sformatf("B_c%0d_dbg_ack", i), dbg_ack[1], (i == 5) ? 1 : 0);
      if (i == 5) begin
        chk("B_dbg_rdata", dbg_rdata[1], 32'h12345678);
        set_req(1, 1, 1'b0, 1'b0, '0, '0);
      end
    end

    // Address frozen at grant
    access(1, 1, 1'b1, 9'h010, 32'h10101010, n, rd);
    access(1, 1, 1'b1, 9'h020, 32'h20202020, n, rd);
    wait_idle(1);
    set_req(1, 0, 1'b1, 1'b0, 9'h010, '0);
    @(negedge clock);
    chk("D_c1_ram_addr", ram_addr[1], 32'h010);
    @(negedge clock);
    cpu_addr[1] = 9'h020;
    @(negedge clock);
    chk("D_c3_ram_addr", ram_addr[1], 32'h010);
    @(negedge clock);
    chk("D_c4_ram_addr", ram_addr[1], 32'h010);
    @(negedge clock);
    chk("D_c5_ack", cpu_ack[1], 1);
    chk("D_c5_rdata", cpu_rdata[1], 32'h10101010);
    set_req(1, 0, 1'b0, 1'b0, '0, '0);

    // Clear during WAIT
    wait_idle(1);
    set_req(1, 0, 1'b1, 1'b0, 9'h020, '0);
    @(negedge clock);
    @(negedge clock);
    clear[1] = 1'b1;
    set_req(1, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    clear[1] = 1'b0;
    chk("E_ack", cpu_ack[1], 0);
    chk("E_busy", busy[1], 0);
    chk("E_ram_en", ram_en[1], 0);
    chk("E_cpu_rdata", cpu_rdata[1], 0);
    chk("E_dbg_rdata", dbg_rdata[1], 0);
    acks_seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (cpu_ack[1] || dbg_ack[1]) acks_seen++;
    end
    chk("E_no_late_ack", acks_seen, 0);
    access(1, 0, 1'b0, 9'h020, '0, n, rd);
    chk("E_after_lat", n, 5);
    chk("E_after_rdata", rd, 32'h20202020);

    tie_run(0, 1'b0, 2);
    tie_run(0, 1'b1, 4);
    tie_run(1, 1'b0, 2);

    // Randomized traffic against a memory scoreboard
    for (int k = 0; k < 2; k++) begin
      pulse_clear(k);
      for (int s = 0; s < 8; s++) begin
        sb[s] = $urandom();
        access(k, 1, 1'b1, slot_addr(s), sb[s], n, rd);
      end
      wait_idle(k);
      last_rd[0] = '0; last_rd[1] = '0;
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 1200; c++) begin
        @(negedge clock);
        if (c >= 400 && pend[0] == 0 && pend[1] == 0) break;
        if (cpu_ack[k] || dbg_ack[k])
          chk($sformatf("rnd_k%0d_ack_excl", k), cpu_ack[k] & dbg_ack[k], 0);
        for (int p = 0; p < 2; p++) begin
          if (pend[p] != 0) begin
            if (get_ack(k, p)) begin
              if (pw[p] == 0) begin
                chk($sformatf("rnd_k%0d_p%0d_rdata", k, p), get_rd(k, p), sb[ps[p]]);
                last_rd[p] = sb[ps[p]];
              end else begin
                sb[ps[p]] = pdat[p];
              end
              chk($sformatf("rnd_k%0d_p%0d_other_rdata", k, p), get_rd(k, 1-p), last_rd[1-p]);
              pend[p] = 0;
              set_req(k, p, 1'b0, 1'b0, '0, '0);
            end else begin
              age[p]++;
              if (age[p] > 60) begin
                bound_fail($sformatf("rnd_k%0d_p%0d_ack", k, p), age[p]);
                pend[p] = 0;
                set_req(k, p, 1'b0, 1'b0, '0, '0);
              end
            end
          end else if (c < 400 && $urandom_range(0, (p == 0) ? 3 : 2) == 0) begin
            pend[p] = 1;
            age[p] = 0;
            pw[p] = int'($urandom_range(0, 1));
            ps[p] = int'($urandom_range(0, 7));
            pdat[p] = $urandom();
            set_req(k, p, 1'b1, pw[p][0], slot_addr(ps[p]), pdat[p]);
          end
        end
      end
      wait_idle(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
